// File: rtl/periph_bus.sv
// rtl/periph_bus.sv - memory-mapped timer, LED, switch and hex seven-segment peripheral
// Timer registers (TH/TL/TCON) and irqout exist only when PERIPH_TIMER_EN is defined.
module periph_bus #(
  parameter logic [31:0] ADDR_BASE = 32'h4000_0000
) (
  input  logic        sysclk,
  input  logic        Reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [6:0]  digi_out1,
  output logic [6:0]  digi_out2,
  output logic [6:0]  digi_out3,
  output logic [6:0]  digi_out4,
  output logic        irqout
);

  logic       in_win;
  logic [5:0] word;
  logic       unused_addr;

  assign in_win      = (addr[31:8] == ADDR_BASE[31:8]);
  assign word        = addr[7:2];
  assign unused_addr = ^addr[1:0];

  logic [31:0] th_rd, tl_rd, tcon_rd;

`ifdef PERIPH_TIMER_EN
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        wr_th, wr_tl, wr_tcon;
  logic        ovf, irq_set;

  assign wr_th   = wr && in_win && (word == 6'd0);
  assign wr_tl   = wr && in_win && (word == 6'd1);
  assign wr_tcon = wr && in_win && (word == 6'd2);

  // CPU writes override the count; the pending bit ORs in an overflow so it is never lost.
  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    tcon_d  = tcon_q;
    ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    irq_set = ovf && tcon_q[1];
    if (tcon_q[0]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (irq_set) begin
      tcon_d[2] = 1'b1;
    end
    if (wr_th) begin
      th_d = wdata;
    end
    if (wr_tl) begin
      tl_d = wdata;
    end
    if (wr_tcon) begin
      tcon_d = {wdata[2] | irq_set, wdata[1:0]};
    end
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_rd   = th_q;
  assign tl_rd   = tl_q;
  assign tcon_rd = {29'd0, tcon_q};
  assign irqout  = tcon_q[2];
`else
  logic unused_wdata;

  assign th_rd        = '0;
  assign tl_rd        = '0;
  assign tcon_rd      = '0;
  assign irqout       = 1'b0;
  assign unused_wdata = ^wdata[31:20];
`endif

  logic [7:0]  led_q, led_d;
  logic [19:0] digi_q, digi_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (wr && in_win && (word == 6'd3)) begin
      led_d = wdata[7:0];
    end
    if (wr && in_win && (word == 6'd5)) begin
      digi_d = wdata[19:0];
    end
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      led_q     <= '0;
      digi_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led = led_q;

  always_comb begin
    rdata = '0;
    if (rd && in_win) begin
      case (word)
        6'd0:    rdata = th_rd;
        6'd1:    rdata = tl_rd;
        6'd2:    rdata = tcon_rd;
        6'd3:    rdata = {24'd0, led_q};
        6'd4:    rdata = {24'd0, sw_sync_q};
        6'd5:    rdata = {12'd0, digi_q};
        default: rdata = '0;
      endcase
    end
  end

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign digi_out1 = digi_q[16] ? hex2seg(digi_q[3:0])   : 7'b1111111;
  assign digi_out2 = digi_q[17] ? hex2seg(digi_q[7:4])   : 7'b1111111;
  assign digi_out3 = digi_q[18] ? hex2seg(digi_q[11:8])  : 7'b1111111;
  assign digi_out4 = digi_q[19] ? hex2seg(digi_q[15:12]) : 7'b1111111;

endmodule

// File: doc/periph_bus.md
# periph_bus

Memory-mapped peripheral block sitting directly downstream of the single-cycle MIPS core's data-memory port. It decodes the 0x4000_00xx I/O window and provides a programmable timer with interrupt request, an 8-bit LED register, synchronised switch input and a four-digit hex seven-segment display. The core's load/store unit drives it, and its outputs go straight to board pins and the core's interrupt input.

## Interface
- `ADDR_BASE`, 32'h4000_0000: base of the I/O window; registers at word offsets 0x00–0x14.
- `sysclk` in 1: system clock; all state updates on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `rd` in 1: read strobe from core (same cycle as `addr`).
- `wr` in 1: write strobe from core.
- `addr` in 32: byte address; bits [1:0] ignored.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational.
- `switch` in 8: raw board switches, asynchronous.
- `led` out 8: LED register.
- `digi_out1`..`digi_out4` out 7 each: segments {g,f,e,d,c,b,a}, active-low; digit1 = least significant nibble.
- `irqout` out 1: timer interrupt request, level.

## Operation
- Register map, offsets from `ADDR_BASE`:
  - 0x00 TH: 32-bit reload value, R/W.
  - 0x04 TL: 32-bit counter, R/W.
  - 0x08 TCON: bit0 enable, bit1 irq-enable, bit2 irq-pending; bits [31:3] read 0, writes ignored.
  - 0x0C LED: bits [7:0] R/W; upper bits read 0.
  - 0x10 SW: bits [7:0] = synchronised switches, read-only; writes ignored.
  - 0x14 DIGI: bits [15:0] four hex nibbles, bits [19:16] per-digit enable (bit16 → digit1); upper bits read 0.
- Address outside the six words, or `rd`=0: `rdata`=0. Writes outside the window are ignored.
- Timer, when TCON[0]=1, each cycle:
  - TL≠32'hFFFF_FFFF: TL←TL+1.
  - TL=32'hFFFF_FFFF: TL←TH, and TCON[2]←1 if TCON[1]=1.
- `irqout` = TCON[2]. It is cleared only by a CPU write of 0 to bit 2.
- Simultaneous events:
  - CPU write to TL in the same cycle as an increment or overflow: the written value wins; no reload.
  - CPU write to TCON in the same cycle as an overflow: the written bits 1:0 take effect; bit2 = written bit2 OR overflow-set, so a pending interrupt is never lost.
- Switch path: two-flop synchroniser, reset to 0.
- Display: each enabled digit decodes its nibble 0–F to standard hex glyphs, active-low (0→7'b1000000, 8→7'b0000000, F→7'b0001110). Disabled digit → 7'b1111111.

## Timing
- Writes commit on the `sysclk` rising edge where `wr`=1. A same-cycle `rd` of the same address returns the old value.
- Reads are zero-latency combinational from registered state.
- A change on `switch` is visible on SW reads after 2 rising edges.
- The timer period with TL starting at TH is (2^32 − TH) cycles from enable to the first overflow. `irqout` rises on the edge that performs the reload.
- Segment outputs are combinational from DIGI; they change the cycle after the write.
- Reset (asynchronous, at any time, including mid-count):
  - TH=TL=TCON=LED=DIGI=0, synchroniser=0.
  - `led`=0, `irqout`=0, `rdata`=0.
  - All `digi_out`=7'b1111111 (all digits disabled).

## Configuration
- `PERIPH_TIMER_EN` defined: timer, TH/TL/TCON and `irqout` behave as described.
- Not defined: no timer logic is synthesised. Offsets 0x00–0x08 read 0 and ignore writes; `irqout` is tied to 0. LED, SW and DIGI are unchanged.

## Test plan
- Reset test: assert `Reset_n`=0 mid-run with TL counting. Required: `led`=0, `irqout`=0, all `digi_out`=7'h7F immediately; after release, TL reads 0.
- Timer test: write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3. Required: `irqout` rises 4 cycles after TCON write commits; TL reads FFFF_FFFC next; the next overflow follows 4 cycles later. Writing TCON=3 clears `irqout`.
- Collision test: write TCON=3 in the exact overflow cycle with bit2=0. Required: `irqout`=1 afterwards. Write TL=5 in the overflow cycle: required TL=5 next cycle.
- LED/SW test: write LED=32'h1A5 → `led`=8'hA5, LED reads 32'hA5. Set `switch`=8'b0000_0010 → SW reads 2 after two edges, 0 before.
- Display test: write DIGI=32'h000F_12AF → `digi_out1`=7'b0001110 (F), `digi_out2`=7'b0001000 (A), `digi_out3`=7'b0100100 (2), `digi_out4`=7'b1111001 (1). Write DIGI=32'h0005_1234 → `digi_out2` and `digi_out4` = 7'h7F.
- Decode/macro test: read 0x4000_0018 → `rdata`=0. Without `PERIPH_TIMER_EN`: write TCON=3, read 0x08 → 0, `irqout` stays 0.
